acc_sequencer: RTL and testbench

Instruction generator for the accumulation phase of the core. After all kij passes have written partial sums into the psum memory, it computes, for every output pixel, the nine psum addresses belonging to that pixel. It then drives the pmem read, accumulate and clear controls that the SFU consumes. Its outputs replace the hand-sequenced A_pmem/CEN_pmem/WEN_pmem/acc fields of the core instruction word, and it tells the consumer when sfp_out holds a finished pixel.

---
 rtl/acc_sequencer.sv | 173 +++++++++++++++++
 tb/tb_acc_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// rtl/acc_sequencer.sv - psum accumulation sequencer driving pmem reads and SFU acc/clear per output pixel
module acc_sequencer #(
  parameter int ksize   = 3,
  parameter int in_w    = 6,
  parameter int out_w   = 4,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               CEN_pmem,
  output logic               WEN_pmem,
  output logic [addr_bw-1:0] A_pmem,
  output logic               acc,
  output logic               acc_clr,
  output logic               out_valid,
  output logic [3:0]         out_idx
);

  localparam int LEN_NIJ  = in_w * in_w;
  localparam int LEN_ONIJ = out_w * out_w;
  localparam int KW       = (ksize > 1) ? $clog2(ksize) : 1;
  localparam int OW       = (out_w > 1) ? $clog2(out_w) : 1;

  localparam logic [KW-1:0]      KMAX     = KW'(ksize - 1);
  localparam logic [OW-1:0]      OMAX     = OW'(out_w - 1);
  localparam logic [3:0]         IDX_LAST = 4'(LEN_ONIJ - 1);
  // Next kj: next kij plane plus one column. Next ki: next plane, one row down, back to column 0.
  localparam logic [addr_bw-1:0] STEP_KJ  = addr_bw'(LEN_NIJ + 1);
  localparam logic [addr_bw-1:0] STEP_KI  = addr_bw'(LEN_NIJ + in_w - ksize + 1);
  localparam logic [addr_bw-1:0] STEP_COL = addr_bw'(1);
  localparam logic [addr_bw-1:0] STEP_ROW = addr_bw'(in_w - out_w + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_READ,
    S_LAST,
    S_WAIT,
    S_VALID,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        ki_q, ki_d, kj_q, kj_d;
  logic [OW-1:0]        ocol_q, ocol_d;
  logic [addr_bw-1:0]   base_q, base_d;
  logic [addr_bw-1:0]   addr_q, addr_d;
  logic [3:0]           idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cen_q, cen_d;
  logic                 acc_q, acc_d;
  logic                 clr_q, clr_d;
  logic                 valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    ki_d    = ki_q;
    kj_d    = kj_q;
    ocol_d  = ocol_q;
    base_d  = base_q;
    addr_d  = addr_q;
    idx_d   = idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          ocol_d  = '0;
          base_d  = '0;
          idx_d   = '0;
        end
      end
      S_CLR: begin
        state_d = S_READ;
        ki_d    = '0;
        kj_d    = '0;
        addr_d  = base_q;
      end
      S_READ: begin
        if (kj_q == KMAX) begin
          if (ki_q == KMAX) begin
            state_d = S_LAST;
          end else begin
            ki_d   = ki_q + KW'(1);
            kj_d   = '0;
            addr_d = addr_q + STEP_KI;
          end
        end else begin
          kj_d   = kj_q + KW'(1);
          addr_d = addr_q + STEP_KJ;
        end
      end
      S_LAST:  state_d = S_WAIT;
      S_WAIT:  state_d = S_VALID;
      S_VALID: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLR;
            idx_d   = idx_q + 4'd1;
            if (ocol_q == OMAX) begin
              ocol_d = '0;
              base_d = base_q + STEP_ROW;
            end else begin
              ocol_d = ocol_q + OW'(1);
              base_d = base_q + STEP_COL;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they land in registers.
    busy_d  = (state_d == S_CLR) || (state_d == S_READ) || (state_d == S_LAST) ||
              (state_d == S_WAIT) || (state_d == S_VALID);
    done_d  = (state_d == S_DONE);
    cen_d   = (state_d != S_READ);
    acc_d   = (state_q == S_READ);
    clr_d   = (state_d == S_CLR);
    valid_d = (state_d == S_VALID);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ki_q    <= '0;
      kj_q    <= '0;
      ocol_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cen_q   <= 1'b1;
      acc_q   <= 1'b0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ki_q    <= ki_d;
      kj_q    <= kj_d;
      ocol_q  <= ocol_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cen_q   <= cen_d;
      acc_q   <= acc_d;
      clr_q   <= clr_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign CEN_pmem  = cen_q;
  assign WEN_pmem  = 1'b1;
  assign A_pmem    = addr_q;
  assign acc       = acc_q;
  assign acc_clr   = clr_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// tb/tb_acc_sequencer.sv - randomized self-checking bench for acc_sequencer against a per-pixel script model
module tb_acc_sequencer;

  localparam int KS   = 3;
  localparam int IW   = 6;
  localparam int OW   = 4;
  localparam int AW   = 11;
  localparam int NPIX = OW * OW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, CEN_pmem, WEN_pmem, acc, acc_clr, out_valid;
  logic [AW-1:0] A_pmem;
  logic [3:0]    out_idx;

  acc_sequencer #(.ksize(KS), .in_w(IW), .out_w(OW), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
    .busy(busy), .done(done), .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem),
    .A_pmem(A_pmem), .acc(acc), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          cen;
    logic          acc;
    logic          clr;
    logic          valid;
    logic [AW-1:0] a;
    logic [3:0]    idx;
  } rec_t;

  rec_t cur;
  rec_t q[$];
  int   p;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  int   n_acc, n_clr, n_done, first_clr, done_cyc, kcnt;
  int   addr_log[NPIX][9];
  int   accp[NPIX];
  int   vdur[NPIX];

  int   run_end  = -1;
  int   seen     = -1;
  bit   all_done = 1'b0;

  function automatic rec_t mk(logic b, logic d, logic c, logic ac, logic cl, logic v, int a, int idx);
    rec_t r;
    r.busy = b; r.done = d; r.cen = c; r.acc = ac; r.clr = cl; r.valid = v;
    r.a = AW'(a); r.idx = 4'(idx);
    return r;
  endfunction

  function automatic int paddr(int pix, int k);
    int orow, ocol, ki, kj;
    orow = pix / OW; ocol = pix % OW; ki = k / KS; kj = k % KS;
    return k * IW * IW + (orow + ki) * IW + (ocol + kj);
  endfunction

  // One pixel as a fixed cycle script: clear, nine reads, trailing operand, settle, then valid.
  task automatic build(int pix);
    q.push_back(mk(1, 0, 1, 0, 1, 0, 0, pix));
    for (int k = 0; k < KS * KS; k++) q.push_back(mk(1, 0, 0, k > 0, 0, 0, paddr(pix, k), pix));
    q.push_back(mk(1, 0, 1, 1, 0, 0, 0, pix));
    q.push_back(mk(1, 0, 1, 0, 0, 0, 0, pix));
    q.push_back(mk(1, 0, 1, 0, 0, 1, 0, pix));
  endtask

  task automatic check_eq(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_logs();
    n_acc = 0; n_clr = 0; n_done = 0; first_clr = -1; done_cyc = -1; kcnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      accp[i] = 0; vdur[i] = 0;
      for (int k = 0; k < 9; k++) addr_log[i][k] = -1;
    end
  endtask

  always @(negedge clk) begin
    bit ok;
    int exp0[9];
    int exp5[9];
    if (cyc == 0) begin
      cur = mk(0, 0, 1, 0, 0, 0, 0, 0);
      clear_logs();
    end
    cyc++;

    ok = (busy == cur.busy) && (done == cur.done) && (CEN_pmem == cur.cen) && (WEN_pmem == 1'b1) &&
         (acc == cur.acc) && (acc_clr == cur.clr) && (out_valid == cur.valid) &&
         (cur.cen || (A_pmem == cur.a)) && (!cur.busy || (out_idx == cur.idx));
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cycle %0d outputs: got busy=%b done=%b cen=%b wen=%b a=%0d acc=%b clr=%b valid=%b idx=%0d, expected busy=%b done=%b cen=%b wen=1 a=%0d acc=%b clr=%b valid=%b idx=%0d",
               cyc, busy, done, CEN_pmem, WEN_pmem, A_pmem, acc, acc_clr, out_valid, out_idx,
               cur.busy, cur.done, cur.cen, cur.a, cur.acc, cur.clr, cur.valid, cur.idx);
    end

    if (acc_clr) begin
      n_clr++;
      if (first_clr < 0) first_clr = cyc;
      kcnt = 0;
    end
    if (!CEN_pmem && kcnt < 9) begin
      addr_log[out_idx][kcnt] = int'(A_pmem);
      kcnt++;
    end
    if (acc) accp[out_idx]++;
    if (out_valid) vdur[out_idx]++;
    if (out_valid && out_ready && !reset) begin
      check_eq("accept order", int'(out_idx), n_acc);
      n_acc++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end

    if (reset) begin
      cur = mk(0, 0, 1, 0, 0, 0, 0, 0);
      q.delete();
    end else if (cur.valid) begin
      if (out_ready) begin
        if (p == NPIX - 1) cur = mk(0, 1, 1, 0, 0, 0, 0, 0);
        else begin
          p++;
          build(p);
          cur = q.pop_front();
        end
      end
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (!cur.busy && !cur.done && start) begin
      p = 0;
      build(0);
      cur = q.pop_front();
    end else begin
      cur = mk(0, 0, 1, 0, 0, 0, 0, 0);
    end

    if (run_end != seen) begin
      seen = run_end;
      case (run_end)
        0: check_eq("reset values", int'({busy, done, CEN_pmem, WEN_pmem, acc, acc_clr, out_valid, A_pmem, out_idx}),
                    int'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 4'd0}));
        1: begin
          exp0 = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
          exp5 = '{7, 44, 81, 121, 158, 195, 235, 272, 309};
          for (int k = 0; k < 9; k++) check_eq("pixel0 addr", addr_log[0][k], exp0[k]);
          for (int k = 0; k < 9; k++) check_eq("pixel5 addr", addr_log[5][k], exp5[k]);
          check_eq("pixel15 last addr", addr_log[15][8], 323);
          check_eq("run1 accepts", n_acc, 16);
          check_eq("run1 acc_clr pulses", n_clr, 16);
          check_eq("run1 done pulses", n_done, 1);
          check_eq("run1 done offset", done_cyc - first_clr, 208);
          for (int i = 0; i < NPIX; i++) check_eq("run1 acc cycles per pixel", accp[i], 9);
          for (int i = 0; i < NPIX; i++) check_eq("run1 valid cycles per pixel", vdur[i], 1);
        end
        2: begin
          check_eq("backpressure pixel3 valid cycles", vdur[3], 6);
          check_eq("run2 accepts", n_acc, 16);
          check_eq("run2 done pulses", n_done, 1);
        end
        3: begin
          check_eq("run3 done pulses", n_done, 1);
          check_eq("run3 accepts", n_acc, 16);
          check_eq("run3 acc_clr pulses", n_clr, 16);
        end
        4: check_eq("aborted run done pulses", n_done, 0);
        5: begin
          check_eq("recovery done pulses", n_done, 1);
          check_eq("recovery accepts", n_acc, 16);
        end
        default: ;
      endcase
      clear_logs();
    end

    if (all_done) begin
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic do_run(int mode, int id);
    int vcnt;
    vcnt = 0;
    out_ready = (mode != 2);
    start = 1'b1;
    @(posedge clk); #1;
    if (mode == 3) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      if (mode == 2) begin
        if (out_valid && out_idx == 4'd3) begin
          vcnt++;
          out_ready = (vcnt >= 6);
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      if (mode >= 2) start = busy && ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 run_end = id;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 run_end = 0;
    repeat (2) @(posedge clk);
    #1;

    do_run(1, 1);
    do_run(2, 2);
    do_run(3, 3);

    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 300 && !(out_idx == 4'd2 && !CEN_pmem); t++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1 run_end = 4;
    repeat (2) @(posedge clk);
    #1;

    do_run(1, 5);
    all_done = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
